ps2_key_ctrl: RTL

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_key_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scan-code decoder: pops the receiver FIFO and tracks make/break key state
module ps2_key_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_ps2_data,
    input  logic       i_ps2_ready,
    input  logic       i_ps2_overflow,
    input  logic       i_ovf_clr,
    output logic       o_nextdata_n,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_valid,
    output logic       o_key_press,
    output logic [7:0] o_key_count,
    output logic       o_overflow
);

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_DECODE,
        ST_WAIT
    } state_t;

    state_t     state;
    logic [7:0] byte_q;
    logic       ext_q;
    logic       brk_q;
    logic       held_match;

    // The byte plus pending E0 prefix names the same key that is currently reported as held
    assign held_match = o_key_valid && (o_key_code == byte_q) && (o_key_ext == ext_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            byte_q       <= 8'h00;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            o_nextdata_n <= 1'b1;
            o_key_code   <= 8'h00;
            o_key_ext    <= 1'b0;
            o_key_valid  <= 1'b0;
            o_key_press  <= 1'b0;
            o_key_count  <= 8'h00;
            o_overflow   <= 1'b0;
        end else begin
            o_key_press <= 1'b0;

            if (i_ps2_overflow) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    o_nextdata_n <= 1'b1;
                    if (i_en && i_ps2_ready) begin
                        byte_q       <= i_ps2_data;
                        o_nextdata_n <= 1'b0;
                        state        <= ST_POP;
                    end
                end
                ST_POP: begin
                    o_nextdata_n <= 1'b1;
                    state        <= ST_DECODE;
                end
                ST_DECODE: begin
                    state <= ST_WAIT;
                    if (byte_q == PREFIX_EXT) begin
                        ext_q <= 1'b1;
                    end else if (byte_q == PREFIX_BRK) begin
                        brk_q <= 1'b1;
                    end else begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        if (brk_q) begin
                            if (held_match) begin
                                o_key_valid <= 1'b0;
                            end
                        end else if (!held_match) begin
                            // Typematic repeats of the held key fall through without a press
                            o_key_code  <= byte_q;
                            o_key_ext   <= ext_q;
                            o_key_valid <= 1'b1;
                            o_key_count <= o_key_count + 8'd1;
                            o_key_press <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    o_nextdata_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
